// File: rtl/vscale_xvec_mem_seq.sv
// Whole-vector load/store sequencer between the xvec register file and the 32-bit dmem port.
// One memory beat per lane; stores snapshot the register once, loads commit with one wide write.
module vscale_xvec_mem_seq #(
  parameter int NUM_LANES      = 32,
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_store,
  input  logic [REG_ADDR_WIDTH-1:0]      req_reg,
  input  logic [31:0]                    req_base,
  input  logic [31:0]                    req_stride,
  output logic [REG_ADDR_WIDTH-1:0]      rf_ra,
  input  logic [NUM_LANES*XPR_LEN-1:0]   rf_rd,
  output logic                           rf_wen,
  output logic [REG_ADDR_WIDTH-1:0]      rf_wa,
  output logic [NUM_LANES*XPR_LEN-1:0]   rf_wd,
  output logic                           rf_xvec_mode,
  output logic                           dmem_en,
  output logic                           dmem_wen,
  output logic [31:0]                    dmem_addr,
  output logic [XPR_LEN-1:0]             dmem_wdata,
  input  logic [XPR_LEN-1:0]             dmem_rdata,
  input  logic                           dmem_wait,
  output logic                           busy,
  output logic                           done
);

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_ADDR, S_DATA, S_WB, S_DONE
  } state_t;

  state_t                         r_state, w_next;
  logic                           r_store;
  logic [REG_ADDR_WIDTH-1:0]      r_reg;
  logic [31:0]                    r_addr;
  logic [31:0]                    r_stride;
  logic [LW-1:0]                  r_lane;
  logic [NUM_LANES*XPR_LEN-1:0]   r_buf;
  logic                           w_last;

  assign w_last = (r_lane == LAST_LANE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = req_store ? S_SNAP : S_ADDR;
      S_SNAP: w_next = S_ADDR;
      S_ADDR: if (!dmem_wait) w_next = S_DATA;
      S_DATA: if (!dmem_wait) w_next = w_last ? (r_store ? S_DONE : S_WB) : S_ADDR;
      S_WB:   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store  <= 1'b0;
      r_reg    <= '0;
      r_addr   <= '0;
      r_stride <= '0;
      r_lane   <= '0;
      r_buf    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_store  <= req_store;
          r_reg    <= req_reg;
          r_addr   <= req_base;
          r_stride <= req_stride;
          r_lane   <= '0;
        end
        // x0 is forced to zero here as well so a store of x0 never depends on the regfile.
        S_SNAP: r_buf <= (r_reg == '0) ? '0 : rf_rd;
        S_DATA: if (!dmem_wait) begin
          if (!r_store) r_buf[r_lane*XPR_LEN +: XPR_LEN] <= dmem_rdata;
          if (!w_last) begin
            r_lane <= r_lane + 1'b1;
            r_addr <= r_addr + r_stride;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign rf_xvec_mode = busy;
  assign rf_ra        = r_reg;
  assign rf_wa        = r_reg;
  assign rf_wd        = r_buf;
  assign rf_wen       = (r_state == S_WB) && (r_reg != '0);
  assign dmem_en      = (r_state == S_ADDR);
  assign dmem_wen     = (r_state == S_ADDR) && r_store;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_buf[r_lane*XPR_LEN +: XPR_LEN];

endmodule

// File: tb/tb_vscale_xvec_mem_seq.sv
// Directed bench for vscale_xvec_mem_seq: regfile and memory models, table of vector ops,
// plus hand-written reset-state and mid-operation reset sequences.
module tb_vscale_xvec_mem_seq;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_store;
  logic [4:0]    req_reg;
  logic [31:0]   req_base, req_stride;
  logic [4:0]    rf_ra, rf_wa;
  logic [1023:0] rf_rd, rf_wd;
  logic          rf_wen, rf_xvec_mode;
  logic          dmem_en, dmem_wen, dmem_wait;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic          busy, done;

  always #5 clk = ~clk;

  vscale_xvec_mem_seq #(.NUM_LANES(32), .XPR_LEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_reg(req_reg), .req_base(req_base), .req_stride(req_stride),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_xvec_mode(rf_xvec_mode), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_wait(dmem_wait), .busy(busy), .done(done)
  );

  function automatic logic [31:0] rf_lane(input logic [4:0] r, input int i);
    if (r == 5'd0) return 32'h0;
    if (r == 5'd3) return 32'h100 + 32'(i);
    return {11'h0, r, 16'h0} | 32'(i * 3 + 1);
  endfunction

  always_comb begin
    rf_rd = '0;
    for (int i = 0; i < 32; i++) rf_rd[i*32 +: 32] = rf_lane(rf_ra, i);
  end

  // Current-operation expectations and wait plan, set by the stimulus process.
  logic        cur_store;
  logic [4:0]  cur_reg;
  logic [31:0] cur_base, cur_stride, cur_roff;
  int          cfg_wa_lane, cfg_wa_cyc, cfg_wd_lane, cfg_wd_cyc;
  logic        mon_clr;

  // Monitor state, written only by the posedge monitor.
  int          acc_cnt, wr_cnt, wen_cnt, addr_err, data_err, phase_err, wcnt_a, wcnt_d;
  logic        pending;
  logic [4:0]  last_wa;
  logic [31:0] last_addr;

  function automatic logic [31:0] exp_addr(input int k);
    return cur_base + cur_stride * 32'(k);
  endfunction

  assign dmem_rdata = last_addr + cur_roff;

  always @(posedge clk) begin
    if (mon_clr) begin
      acc_cnt = 0; wr_cnt = 0; wen_cnt = 0; addr_err = 0; data_err = 0; phase_err = 0;
      wcnt_a = 0; wcnt_d = 0; pending = 1'b0; last_wa = '0; last_addr = '0;
    end else if (reset) begin
      acc_cnt = 0; pending = 1'b0;
      if (dmem_en || rf_wen) phase_err++;
    end else begin
      if (rf_xvec_mode != busy) phase_err++;
      if (pending) begin
        if (dmem_en) phase_err++;
        if (cur_store && dmem_wdata != rf_lane(cur_reg, acc_cnt - 1)) data_err++;
        if (dmem_wait) wcnt_d++;
        else begin
          pending = 1'b0;
          if (cur_store) wr_cnt++;
        end
      end else if (dmem_en) begin
        if (dmem_addr != exp_addr(acc_cnt) || dmem_wen != cur_store) addr_err++;
        if (dmem_wait) wcnt_a++;
        else begin
          acc_cnt++;
          pending = 1'b1;
          last_addr = dmem_addr;
        end
      end
      if (rf_wen) begin
        wen_cnt++;
        last_wa = rf_wa;
        for (int i = 0; i < 32; i++)
          if (rf_wd[i*32 +: 32] != exp_addr(i) + cur_roff) data_err++;
      end
    end
  end

  always @(negedge clk) begin
    dmem_wait = (dmem_en && !pending && acc_cnt == cfg_wa_lane && wcnt_a < cfg_wa_cyc) ||
                (pending && acc_cnt == cfg_wd_lane + 1 && wcnt_d < cfg_wd_cyc);
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    logic        store;
    logic [4:0]  rg;
    logic [31:0] base, stride, roff;
    int          wa_lane, wa_cyc, wd_lane, wd_cyc, exp_cyc;
    logic        poke;
  } vec_t;

  vec_t vecs[9];

  task automatic run_op(input int idx);
    vec_t v;
    int   cyc;
    v = vecs[idx];
    cur_store = v.store; cur_reg = v.rg; cur_base = v.base; cur_stride = v.stride;
    cur_roff = v.roff;
    cfg_wa_lane = v.wa_lane; cfg_wa_cyc = v.wa_cyc; cfg_wd_lane = v.wd_lane; cfg_wd_cyc = v.wd_cyc;
    @(negedge clk) mon_clr = 1'b1;
    @(negedge clk) begin
      mon_clr = 1'b0; req_valid = 1'b1; req_store = v.store; req_reg = v.rg;
      req_base = v.base; req_stride = v.stride;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (v.poke && cyc == 10) begin req_valid = 1'b1; req_store = ~v.store; end
      if (v.poke && cyc == 13) req_valid = 1'b0;
    end
    chk($sformatf("v%0d done_cycle", idx), 32'(cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d accesses", idx), 32'(acc_cnt), 32'd32);
    chk($sformatf("v%0d addr_errs", idx), 32'(addr_err), 32'd0);
    chk($sformatf("v%0d data_errs", idx), 32'(data_err), 32'd0);
    chk($sformatf("v%0d phase_errs", idx), 32'(phase_err), 32'd0);
    chk($sformatf("v%0d rf_wen_count", idx), 32'(wen_cnt),
        (!v.store && v.rg != 5'd0) ? 32'd1 : 32'd0);
    if (v.store) chk($sformatf("v%0d mem_writes", idx), 32'(wr_cnt), 32'd32);
    else if (v.rg != 5'd0) chk($sformatf("v%0d rf_wa", idx), 32'(last_wa), 32'(v.rg));
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_after_done", idx), {30'h0, busy, req_ready}, 32'b01);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 5'd3,  32'h1000,     32'h4,        32'h0,  -1, 0, -1, 0, 66, 1'b1};
    vecs[1] = '{1'b0, 5'd5,  32'h2000,     32'h8,        32'h0,  -1, 0, -1, 0, 66, 1'b0};
    vecs[2] = '{1'b0, 5'd6,  32'h3000,     32'h4,        32'h55,  7, 3, 20, 2, 71, 1'b0};
    vecs[3] = '{1'b1, 5'd7,  32'h4000,     32'hC,        32'h0,   7, 3, 20, 2, 71, 1'b0};
    vecs[4] = '{1'b0, 5'd9,  32'hFFFFFFF8, 32'h4,        32'h3,  -1, 0, -1, 0, 66, 1'b0};
    vecs[5] = '{1'b1, 5'd2,  32'h500,      32'hFFFFFFFC, 32'h0,  -1, 0, -1, 0, 66, 1'b0};
    vecs[6] = '{1'b0, 5'd0,  32'h600,      32'h4,        32'h0,  -1, 0, -1, 0, 66, 1'b0};
    vecs[7] = '{1'b1, 5'd0,  32'h700,      32'h4,        32'h0,  -1, 0, -1, 0, 66, 1'b0};
    vecs[8] = '{1'b0, 5'd12, 32'h800,      32'h0,        32'h9,  -1, 0, -1, 0, 66, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_reg = '0;
    req_base = '0; req_stride = '0; mon_clr = 1'b1; dmem_wait = 1'b0;
    cur_store = 1'b0; cur_reg = '0; cur_base = '0; cur_stride = '0; cur_roff = '0;
    cfg_wa_lane = -1; cfg_wa_cyc = 0; cfg_wd_lane = -1; cfg_wd_cyc = 0;
    #2;
    chk("reset ctrl {ready,busy,done,en,wen,rfwen,xvec}",
        {25'h0, req_ready, busy, done, dmem_en, dmem_wen, rf_wen, rf_xvec_mode}, 32'h40);
    chk("reset dmem_addr", dmem_addr, 32'h0);
    chk("reset dmem_wdata", dmem_wdata, 32'h0);
    chk("reset rf_wd_nonzero", {31'h0, |rf_wd}, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) mon_clr = 1'b0;

    for (int i = 0; i < 9; i++) run_op(i);

    // Abort a load in the DATA phase of lane 10.
    cur_store = 1'b0; cur_reg = 5'd11; cur_base = 32'h7000; cur_stride = 32'h4; cur_roff = '0;
    cfg_wa_lane = -1; cfg_wd_lane = -1;
    @(negedge clk) mon_clr = 1'b1;
    @(negedge clk) begin
      mon_clr = 1'b0; req_valid = 1'b1; req_store = 1'b0; req_reg = 5'd11;
      req_base = 32'h7000; req_stride = 32'h4;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!(pending && acc_cnt == 11) && n < 200) begin @(posedge clk); #1; n++; end
    chk("abort reached lane10 DATA", {31'h0, n < 200}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort {busy,en,ready,done}", {28'h0, busy, dmem_en, req_ready, done}, 32'b0010);
    repeat (2) @(posedge clk);
    #1;
    chk("abort rf_wen_count", 32'(wen_cnt), 32'd0);
    chk("abort phase_errs", 32'(phase_err), 32'd0);
    @(negedge clk) reset = 1'b0;
    run_op(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
